// File: rtl/flag_condition_unit.sv
// flag_condition_unit: registers ZF/CF/SF/OF derived from the ALU result,
// answers condition-code queries one cycle after request, and keeps a small
// LIFO so the control unit can save/restore the flag set.
module flag_condition_unit #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Resultado,
   input  logic             Carry_in,
   input  logic             Overflow_in,
   input  logic             Update,
   input  logic             Push,
   input  logic             Pop,
   input  logic [3:0]       Cond,
   input  logic             Cond_req,
   output logic             Cond_ack,
   output logic             Cond_true,
   output logic             ZF,
   output logic             CF,
   output logic             SF,
   output logic             OF,
   output logic             Stack_full,
   output logic             Stack_empty,
   output logic             Stack_err
);

   localparam int unsigned AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SPW = AW + 1;

   // Flag register, packed {Z,C,S,O}
   logic [3:0]     r_flags;
   logic [SPW-1:0] r_sp;
   logic [3:0]     r_lifo [STACK_DEPTH];
   logic           r_full;
   logic           r_empty;
   logic           r_err;
   logic           r_ack;
   logic           r_true;

   logic           w_z, w_c, w_s, w_o;
   logic           w_push_ok;
   logic           w_pop_ok;
   logic           w_err;
   logic [SPW-1:0] w_sp_inc;
   logic [SPW-1:0] w_sp_dec;
   logic [SPW-1:0] w_sp_next;
   logic [AW-1:0]  w_wr_idx;
   logic [AW-1:0]  w_rd_idx;
   logic [3:0]     w_new_flags;
   logic           w_eval;

   assign w_z = r_flags[3];
   assign w_c = r_flags[2];
   assign w_s = r_flags[1];
   assign w_o = r_flags[0];

   assign w_sp_inc = r_sp + 1'b1;
   assign w_sp_dec = r_sp - 1'b1;
   assign w_wr_idx = r_sp[AW-1:0];
   assign w_rd_idx = w_sp_dec[AW-1:0];

   assign w_new_flags = {~|Resultado, Carry_in, Resultado[WIDTH-1], Overflow_in};

   // Legal stack operations and the error pulse condition
   always_comb begin
      w_push_ok = Push & ~Pop & ~r_full;
      w_pop_ok  = Pop & ~Push & ~r_empty;
      w_err     = (Push & Pop) | (Push & r_full) | (Pop & r_empty);
      w_sp_next = r_sp;
      if (w_push_ok) begin
         w_sp_next = w_sp_inc;
      end else if (w_pop_ok) begin
         w_sp_next = w_sp_dec;
      end
   end

   // Condition-code evaluation on the currently registered flags
   always_comb begin
      w_eval = 1'b0;
      unique case (Cond)
         4'h0: w_eval = w_z;
         4'h1: w_eval = ~w_z;
         4'h2: w_eval = w_c;
         4'h3: w_eval = ~w_c;
         4'h4: w_eval = w_s;
         4'h5: w_eval = ~w_s;
         4'h6: w_eval = w_o;
         4'h7: w_eval = ~w_o;
         4'h8: w_eval = w_c & ~w_z;
         4'h9: w_eval = ~w_c | w_z;
         4'hA: w_eval = (w_s == w_o);
         4'hB: w_eval = (w_s != w_o);
         4'hC: w_eval = ~w_z & (w_s == w_o);
         4'hD: w_eval = w_z | (w_s != w_o);
         4'hE: w_eval = 1'b1;
         4'hF: w_eval = 1'b0;
         default: w_eval = 1'b0;
      endcase
   end

   // Flag register: legal Pop beats Update, otherwise hold
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_flags <= '0;
      end else if (w_pop_ok) begin
         r_flags <= r_lifo[w_rd_idx];
      end else if (Update) begin
         r_flags <= w_new_flags;
      end
   end

   // LIFO storage; Push saves the pre-Update flag value
   always_ff @(posedge CLK) begin
      if (!RST && w_push_ok) begin
         r_lifo[w_wr_idx] <= r_flags;
      end
   end

   // Stack pointer, registered full/empty status and error pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sp    <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_err   <= 1'b0;
      end else begin
         r_sp    <= w_sp_next;
         r_full  <= (w_sp_next == SPW'(STACK_DEPTH));
         r_empty <= (w_sp_next == '0);
         r_err   <= w_err;
      end
   end

   // Condition handshake: ack and result one cycle after request
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ack  <= 1'b0;
         r_true <= 1'b0;
      end else begin
         r_ack  <= Cond_req;
         r_true <= Cond_req & w_eval;
      end
   end

   assign ZF          = r_flags[3];
   assign CF          = r_flags[2];
   assign SF          = r_flags[1];
   assign OF          = r_flags[0];
   assign Cond_ack    = r_ack;
   assign Cond_true   = r_true;
   assign Stack_full  = r_full;
   assign Stack_empty = r_empty;
   assign Stack_err   = r_err;

endmodule

// File: tb/tb_flag_condition_unit.sv
// Bench for flag_condition_unit: directed steps followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_flag_condition_unit;

   localparam int WIDTH = 6;
   localparam int DEPTH = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic [WIDTH-1:0] Resultado = '0;
   logic             Carry_in = 1'b0;
   logic             Overflow_in = 1'b0;
   logic             Update = 1'b0;
   logic             Push = 1'b0;
   logic             Pop = 1'b0;
   logic [3:0]       Cond = '0;
   logic             Cond_req = 1'b0;
   logic             Cond_ack, Cond_true, ZF, CF, SF, OF;
   logic             Stack_full, Stack_empty, Stack_err;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit       m_z, m_c, m_s, m_o;
   bit [3:0] m_stk[$];
   bit       m_ack, m_true, m_err;

   flag_condition_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .Resultado(Resultado), .Carry_in(Carry_in),
      .Overflow_in(Overflow_in), .Update(Update), .Push(Push), .Pop(Pop),
      .Cond(Cond), .Cond_req(Cond_req), .Cond_ack(Cond_ack),
      .Cond_true(Cond_true), .ZF(ZF), .CF(CF), .SF(SF), .OF(OF),
      .Stack_full(Stack_full), .Stack_empty(Stack_empty), .Stack_err(Stack_err)
   );

   always #5 CLK = ~CLK;

   // Condition codes come in complementary pairs: even = base, odd = inverse.
   function automatic bit ref_cond(input int code, input bit z, c, s, o);
      bit base;
      case (code / 2)
         0: base = z;
         1: base = c;
         2: base = s;
         3: base = o;
         4: base = c && !z;
         5: base = (s == o);
         6: base = !z && (s == o);
         default: base = 1'b1;
      endcase
      return (code % 2 == 1) ? !base : base;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst, upd, push, pop, req,
                             input int cond, input int res, input bit c, o);
      int n;
      bit [3:0] v;
      n = m_stk.size();
      if (rst) begin
         {m_z, m_c, m_s, m_o} = 4'b0;
         m_stk.delete();
         m_ack = 0; m_true = 0; m_err = 0;
         return;
      end
      m_ack  = req;
      m_true = req && ref_cond(cond, m_z, m_c, m_s, m_o);
      m_err  = (push && pop) || (push && n == DEPTH) || (pop && n == 0);
      if (push && !pop && n < DEPTH) m_stk.push_back({m_z, m_c, m_s, m_o});
      if (pop && !push && n > 0) begin
         v = m_stk.pop_back();
         {m_z, m_c, m_s, m_o} = v;
      end else if (upd) begin
         m_z = ((res % 64) == 0);
         m_s = ((res % 64) >= 32);
         m_c = c;
         m_o = o;
      end
   endtask

   task automatic step(input bit rst, upd, push, pop, req,
                       input int cond, input int res, input bit c, o);
      RST = rst; Update = upd; Push = push; Pop = pop; Cond_req = req;
      Cond = 4'(cond); Resultado = WIDTH'(res); Carry_in = c; Overflow_in = o;
      @(posedge CLK);
      model_edge(rst, upd, push, pop, req, cond, res, c, o);
      #1;
      chk("ZF", ZF, m_z);
      chk("CF", CF, m_c);
      chk("SF", SF, m_s);
      chk("OF", OF, m_o);
      chk("ack", Cond_ack, m_ack);
      chk("true", Cond_true, m_true);
      chk("full", Stack_full, m_stk.size() == DEPTH);
      chk("empty", Stack_empty, m_stk.size() == 0);
      chk("err", Stack_err, m_err);
   endtask

   initial begin
      logic [15:0] exp_tab;
      exp_tab = 16'b1010010101100110; // bit 15 = code 0

      // 1: reset, then Update 0x00 C=1 O=0, query EQ
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 'h00, 1, 0);
      chk("t1_ZF", ZF, 1'b1);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk("t1_eq", Cond_true, 1'b1);

      // 2: negative result, LT/GE, query coinciding with Update
      step(0, 1, 0, 0, 0, 0, 'h20, 0, 0);
      step(0, 0, 0, 0, 1, 'hB, 0, 0, 0);
      chk("t2_lt", Cond_true, 1'b1);
      step(0, 0, 0, 0, 1, 'hA, 0, 0, 0);
      chk("t2_ge", Cond_true, 1'b0);
      step(0, 1, 0, 0, 1, 'h4, 'h01, 0, 0);
      chk("t2_pre", Cond_true, 1'b1);

      // 3: fill stack with distinct sets, overflow, drain, underflow
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0, 0, 0, (i == 0) ? 0 : 32 + i, i % 2, i / 2);
         step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      end
      chk("t3_full", Stack_full, 1'b1);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("t3_ovf", Stack_err, 1'b1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("t3_unf", Stack_err, 1'b1);

      // 4: Push+Pop, Push+Update, Pop+Update
      step(0, 1, 0, 0, 0, 0, 'h05, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 'h00, 0, 0);
      step(0, 1, 0, 1, 0, 0, 'h3F, 1, 1);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0);

      // 5: sixteen back-to-back queries on Z=1 C=1 S=0 O=0
      step(0, 1, 0, 0, 0, 0, 'h00, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 1, i, 0, 0, 0);
         chk("t5_tab", Cond_true, exp_tab[15 - i]);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 6: reset with request pending and two entries stacked
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 'hE, 'h21, 1, 1);
      chk("t6_ack", Cond_ack, 1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), $urandom_range(0, 15),
              ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 63),
              $urandom_range(0, 1), $urandom_range(0, 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
